// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Free-running 640x480@60 Hz VGA timing generator driven by the 25 MHz pixel
//   clock. It produces the current pixel coordinates for the sprite renderers,
//   a visible-area flag, active-low sync strobes for the DAC/pins and a
//   one-cycle frame_start pulse at position (0,0).
//
// Ports:
//   vga_clk      in   1   pixel clock (25 MHz)
//   reset_n      in   1   asynchronous active-low reset
//   DrawX        out  10  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  10  vertical counter,   0..V_TOTAL-1
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   blank        out  1   1 = visible pixel, 0 = blanking interval
//   frame_start  out  1   high while DrawX==0 and DrawY==0
//   frame_count  out  8   frames since reset, wraps 255->0
//                         (present only when VGA_FRAME_COUNT_EN is defined)
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   Defined   -> adds the frame_count port and its register.
//   Undefined -> port and register absent; all other behaviour identical.
//
// Timing parameters must keep H_TOTAL and V_TOTAL at or below 1024 so the
// 10-bit counters never overflow; no saturation logic is provided.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  // Derived line/frame geometry.
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Counter state and registered decode outputs.
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_start;

  // Next-state counter values and wrap conditions.
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_hc_next;
  logic [9:0] w_vc_next;

  assign w_h_wrap  = (r_hc == H_LAST);
  assign w_v_wrap  = w_h_wrap && (r_vc == V_LAST);
  assign w_hc_next = w_h_wrap ? 10'd0 : (r_hc + 10'd1);
  assign w_vc_next = w_v_wrap ? 10'd0
                   : (w_h_wrap ? (r_vc + 10'd1) : r_vc);

  // NOTE: the sync/blank/frame_start flags are decoded from the *next* counter
  // values and registered alongside the counters, so every output changes on
  // the same edge as DrawX/DrawY. Decoding from r_hc/r_vc instead would lag
  // the coordinates by one pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    // NOTE: state uses non-blocking assignments and an asynchronous reset so
    // the outputs snap to position (0,0) the moment reset_n falls, without
    // waiting for a clock edge.
    if (!reset_n) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b1;
    end else begin
      r_hc          <= w_hc_next;
      r_vc          <= w_vc_next;
      r_hs          <= !((w_hc_next >= H_SYNC_START) && (w_hc_next < H_SYNC_END));
      // vs spans the whole line, porches included, so it depends on vc only.
      r_vs          <= !((w_vc_next >= V_SYNC_START) && (w_vc_next < V_SYNC_END));
      r_blank       <= (w_hc_next < H_VIS_END) && (w_vc_next < V_VIS_END);
      r_frame_start <= (w_hc_next == 10'd0) && (w_vc_next == 10'd0);
    end
  end

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Advances on the frame wrap edge, i.e. the edge where frame_start rises.
  // The 8-bit add wraps 255 -> 0 naturally.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= 8'd0;
    end else if (w_v_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock: a full 640x480 instance (reset, line timing,
// mid-line asynchronous reset) and a small-geometry instance whose short frame
// lets whole frames, the frame_start period and the frame_count wrap be
// exercised within a modest cycle budget. Expected outputs come from an
// arithmetic model of the timing rules indexed by cycles since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Full-size geometry.
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVV = 480, BVF = 10, BVS = 2,  BVB = 33;
  // Small geometry: 16 clocks per line, 12 lines, 192 clocks per frame.
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 2;
  localparam int S_HT    = SHV + SHF + SHS + SHB;
  localparam int S_FRAME = S_HT * (SVV + SVF + SVS + SVB);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } vid_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  logic rst_s = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] dx_b, dy_b, dx_s, dy_s;
  logic       hs_b, vs_b, bl_b, fs_b;
  logic       hs_s, vs_s, bl_s, fs_s;
  logic [7:0] fc_b, fc_s;

  vga_timing_gen u_big (
    .vga_clk     (clk),
    .reset_n     (rst_b),
    .DrawX       (dx_b),
    .DrawY       (dy_b),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (bl_b),
    .frame_start (fs_b)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (fc_b)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
  ) u_small (
    .vga_clk     (clk),
    .reset_n     (rst_s),
    .DrawX       (dx_s),
    .DrawY       (dy_s),
    .hs          (hs_s),
    .vs          (vs_s),
    .blank       (bl_s),
    .frame_start (fs_s)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (fc_s)
`endif
  );

`ifndef VGA_FRAME_COUNT_EN
  assign fc_b = 8'd0;
  assign fc_s = 8'd0;
`endif

  vid_t a_b, a_s;
  assign a_b = {dx_b, dy_b, hs_b, vs_b, bl_b, fs_b, fc_b};
  assign a_s = {dx_s, dy_s, hs_s, vs_s, bl_s, fs_s, fc_s};

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Position n clocks after reset release, derived from the timing rules.
  function automatic vid_t model(input int n, input int hv, input int hf,
                                 input int hsy, input int hb, input int vv,
                                 input int vf, input int vsy, input int vb);
    vid_t e;
    int ht, vt, x, y;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !((x >= hv + hf) && (x < hv + hf + hsy));
    e.vs    = !((y >= vv + vf) && (y < vv + vf + vsy));
    e.blank = (x < hv) && (y < vv);
    e.fs    = (x == 0) && (y == 0);
`ifdef VGA_FRAME_COUNT_EN
    e.fc    = 8'((n / (ht * vt)) % 256);
`else
    e.fc    = 8'd0;
`endif
    return e;
  endfunction

  function automatic vid_t exp_big(input int n);
    return model(n, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
  endfunction

  function automatic vid_t exp_small(input int n);
    return model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  // Scoreboard producers: one expectation per clock, flushed on reset.
  vid_t q_b[$];
  vid_t q_s[$];
  int   n_b = 0;
  int   n_s = 0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) n_b = 0;
    else        n_b = n_b + 1;
    q_b.delete();
    q_b.push_back(exp_big(n_b));
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) n_s = 0;
    else        n_s = n_s + 1;
    q_s.delete();
    q_s.push_back(exp_small(n_s));
  end

  // Monitor: compares on the falling edge, away from the active edge.
  vid_t e_b, e_s;
  int   hs_run  = 0;
  int   vs_run  = 0;
  int   cyc_s   = 0;
  int   last_fs = -1;

  always @(negedge clk) begin
    if (q_b.size() != 0) begin
      e_b = q_b.pop_front();
      check("big_outputs", a_b, e_b);
    end
    if (q_s.size() != 0) begin
      e_s = q_s.pop_front();
      check("small_outputs", a_s, e_s);
    end

    if (!rst_b) hs_run = 0;
    else if (!hs_b) hs_run++;
    else if (hs_run != 0) begin
      check("hs_width", 32'(hs_run), 32'(BHS));
      hs_run = 0;
    end

    if (!rst_s) vs_run = 0;
    else if (!vs_s) vs_run++;
    else if (vs_run != 0) begin
      check("vs_width", 32'(vs_run), 32'(SVS * S_HT));
      vs_run = 0;
    end

    cyc_s++;
    if (!rst_s) last_fs = -1;
    else if (fs_s) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc_s - last_fs), 32'(S_FRAME));
      last_fs = cyc_s;
    end
  end

  int found;
  int ty;
  int target;

  initial begin
    repeat (5) @(posedge clk);
    #3;
    check("reset_big",   a_b, exp_big(0));
    check("reset_small", a_s, exp_small(0));
    rst_b = 1'b1;
    rst_s = 1'b1;

    @(posedge clk);
    #1;
    check("first_edge", 32'({dx_b, fs_b}), 32'({10'd1, 1'b0}));

    // Asynchronous reset of the full-size instance in the middle of hsync.
    ty    = int'($urandom_range(1, 3));
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      if (dx_b == 10'd700 && dy_b == 10'(ty)) begin
        found = 1;
        break;
      end
    end
    check("reach_big_target", 32'(found), 32'd1);
    #2 rst_b = 1'b0;
    #1 check("async_reset_big", a_b, exp_big(0));
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #3 rst_b = 1'b1;
    repeat (2000) @(posedge clk);

    // Let the small instance pass 257 frames so frame_count wraps.
    target = 257 * S_FRAME + int'($urandom_range(1, S_FRAME - 2));
    found  = 0;
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      #1;
      if (n_s >= target) begin
        found = 1;
        break;
      end
    end
    check("reach_small_target", 32'(found), 32'd1);
    #2 rst_s = 1'b0;
    #1 check("async_reset_small", a_s, exp_small(0));
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #3 rst_s = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
